// File: rtl/tdoa_delay_meas.sv
`default_nettype none
// ============================================================================
// Module      : tdoa_delay_meas
// Description : Time-stamps the acoustic onset on six microphones and reports
//               the arrival offset of mics 2..6 relative to mic 1 in ticks,
//               saturated to 4 bits, followed by a fixed-width ena pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tdoa_delay_meas #(
    parameter int CLK_PER_TICK  = 5000,
    parameter int WINDOW_TICKS  = 32,
    parameter int HOLDOFF_TICKS = 2000,
    parameter int ENA_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] mic_trig,
    output logic [3:0] delay12,
    output logic [3:0] delay13,
    output logic [3:0] delay14,
    output logic [3:0] delay15,
    output logic [3:0] delay16,
    output logic       ena,
    output logic       busy,
    output logic       err_order,
    output logic       err_timeout
);

    localparam logic [15:0] c_PRESC_LAST = 16'(CLK_PER_TICK - 1);
    localparam logic [7:0]  c_WINDOW     = 8'(WINDOW_TICKS);
    localparam logic [15:0] c_HOLD_LAST  = 16'(HOLDOFF_TICKS - 1);
    localparam int          c_ENA_W      = (ENA_CYCLES > 1) ? $clog2(ENA_CYCLES) : 1;
    localparam logic [c_ENA_W-1:0] c_ENA_LEFT = c_ENA_W'(ENA_CYCLES - 1);
    localparam logic [c_ENA_W-1:0] c_ENA_ONE  = c_ENA_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_REPORT  = 2'd2,
        S_HOLDOFF = 2'd3
    } state_t;

    state_t             r_state;
    logic [5:0]         r_sync1, r_sync2, r_sync3, r_edge;
    logic [15:0]        r_presc;
    logic [7:0]         r_tick;
    logic [15:0]        r_hold;
    logic [5:0]         r_arrived;
    logic [7:0]         r_arrival [0:5];
    logic [3:0]         r_delay   [1:5];
    logic               r_busy, r_err_order, r_err_timeout, r_ena;
    logic [c_ENA_W-1:0] r_ena_left;

    logic               w_wrap;
    logic [5:0]         w_new;
    logic               w_all;
    logic [5:1]         w_early;
    logic [3:0]         w_sat [1:5];

    assign w_wrap = (r_presc == c_PRESC_LAST);
    assign w_new  = r_edge & ~r_arrived;
    assign w_all  = &(r_arrived | w_new);

    // Two-flop synchronizer per mic, then a registered rising-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
            r_edge  <= '0;
        end else begin
            r_sync1 <= mic_trig;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_edge  <= r_sync2 & ~r_sync3;
        end
    end

    // Offset of mic k+1 versus mic 1: 9-bit difference, negative clamps to 0
    for (genvar k = 1; k < 6; k++) begin : g_delay
        logic [8:0] w_diff;
        assign w_diff     = {1'b0, r_arrival[k]} - {1'b0, r_arrival[0]};
        assign w_early[k] = w_diff[8];
        assign w_sat[k]   = w_diff[8]            ? 4'd0 :
                            (w_diff[7:4] != 4'd0) ? 4'hF : w_diff[3:0];
    end

    // Capture sequencer: arm on first onset, time-stamp arrivals, report, blank echoes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_presc       <= '0;
            r_tick        <= '0;
            r_hold        <= '0;
            r_arrived     <= '0;
            r_busy        <= 1'b0;
            r_err_order   <= 1'b0;
            r_err_timeout <= 1'b0;
            for (int i = 0; i < 6; i++) r_arrival[i] <= '0;
            for (int i = 1; i < 6; i++) r_delay[i]   <= '0;
        end else begin
            r_err_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_presc <= '0;
                    if (|r_edge) begin
                        r_tick    <= '0;
                        r_arrived <= r_edge;
                        r_busy    <= 1'b1;
                        for (int i = 0; i < 6; i++)
                            if (r_edge[i]) r_arrival[i] <= '0;
                        // A fully simultaneous burst needs no capture window
                        r_state <= (&r_edge) ? S_REPORT : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (w_wrap) begin
                        r_presc <= '0;
                        r_tick  <= r_tick + 8'd1;
                    end else begin
                        r_presc <= r_presc + 16'd1;
                    end
                    for (int i = 0; i < 6; i++)
                        if (w_new[i]) r_arrival[i] <= r_tick;
                    r_arrived <= r_arrived | w_new;
                    // Completion wins over a window expiring in the same cycle
                    if (w_all) begin
                        r_state <= S_REPORT;
                    end else if (r_tick == c_WINDOW) begin
                        r_err_timeout <= 1'b1;
                        r_presc       <= '0;
                        r_hold        <= '0;
                        r_state       <= S_HOLDOFF;
                    end
                end
                S_REPORT: begin
                    for (int i = 1; i < 6; i++) r_delay[i] <= w_sat[i];
                    r_err_order <= |w_early;
                    r_presc     <= '0;
                    r_hold      <= '0;
                    r_state     <= S_HOLDOFF;
                end
                S_HOLDOFF: begin
                    if (w_wrap) begin
                        r_presc <= '0;
                        if (r_hold == c_HOLD_LAST) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_hold <= r_hold + 16'd1;
                        end
                    end else begin
                        r_presc <= r_presc + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Capture-done pulse launched by REPORT; runs its full width even into HOLDOFF
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ena      <= 1'b0;
            r_ena_left <= '0;
        end else if (r_state == S_REPORT) begin
            r_ena      <= 1'b1;
            r_ena_left <= c_ENA_LEFT;
        end else if (r_ena_left != '0) begin
            r_ena_left <= r_ena_left - c_ENA_ONE;
        end else begin
            r_ena <= 1'b0;
        end
    end

    assign delay12     = r_delay[1];
    assign delay13     = r_delay[2];
    assign delay14     = r_delay[3];
    assign delay15     = r_delay[4];
    assign delay16     = r_delay[5];
    assign ena         = r_ena;
    assign busy        = r_busy;
    assign err_order   = r_err_order;
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_tdoa_delay_meas.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdoa_delay_meas
// Description : Directed self-checking bench for tdoa_delay_meas with a short
//               tick (10 clk) and holdoff (20 ticks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdoa_delay_meas;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] mic_trig;
    logic [3:0] delay12, delay13, delay14, delay15, delay16;
    logic       ena, busy, err_order, err_timeout;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    int   ena_pulses   = 0;
    int   ena_width    = 0;
    int   ena_rise_cyc = 0;
    int   tmo_count    = 0;
    int   tmo_cyc      = 0;
    logic ena_q        = 1'b0;

    tdoa_delay_meas #(
        .CLK_PER_TICK (10),
        .WINDOW_TICKS (32),
        .HOLDOFF_TICKS(20),
        .ENA_CYCLES   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mic_trig   (mic_trig),
        .delay12    (delay12),
        .delay13    (delay13),
        .delay14    (delay14),
        .delay15    (delay15),
        .delay16    (delay16),
        .ena        (ena),
        .busy       (busy),
        .err_order  (err_order),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Free-running cycle index
    always @(posedge clk) cyc <= cyc + 1;

    // Observe ena pulses and timeout pulses away from the active edge
    always @(negedge clk) begin
        ena_q <= ena;
        if (ena && !ena_q) begin
            ena_pulses   <= ena_pulses + 1;
            ena_rise_cyc <= cyc;
            ena_width    <= 1;
        end else if (ena) begin
            ena_width <= ena_width + 1;
        end
        if (err_timeout) begin
            tmo_count <= tmo_count + 1;
            tmo_cyc   <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] delays();
        return {delay12, delay13, delay14, delay15, delay16};
    endfunction

    function automatic logic [23:0] all_outs();
        return {delays(), ena, busy, err_order, err_timeout};
    endfunction

    // Bounded wait for the block to return to IDLE with ena finished
    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy !== 1'b0 || ena !== 1'b0) && n < 2000);
        check({tag, "_idle"}, 32'(n < 2000), 32'd1);
        cyc_wait(2);
    endtask

    initial begin
        int c0, c6, p0, t0c, n, d;

        // 1: reset held with mic inputs toggling
        rst_n    = 1'b0;
        mic_trig = '0;
        for (int i = 0; i < 12; i++) begin
            cyc_wait(1);
            mic_trig = 6'($urandom);
            if (i % 4 == 3) check("t1_rst_outs", 32'(all_outs()), 32'd0);
        end
        mic_trig = '0;
        cyc_wait(2);
        rst_n = 1'b1;
        cyc_wait(8);
        check("t1_post_rst_outs", 32'(all_outs()), 32'd0);
        check("t1_no_ena", ena_pulses, 0);

        // 2: staircase arrivals 1..5 ticks after mic1
        p0 = ena_pulses;
        cyc_wait(2);
        mic_trig[0] = 1'b1;
        cyc_wait(15);
        mic_trig[1] = 1'b1;
        check("t2_busy", 32'(busy), 32'd1);
        for (int k = 2; k < 6; k++) begin
            cyc_wait(10);
            mic_trig[k] = 1'b1;
        end
        c6 = cyc;
        cyc_wait(20);
        mic_trig = '0;
        wait_idle("t2");
        check("t2_delays", 32'(delays()), 32'h12345);
        check("t2_err_order", 32'(err_order), 32'd0);
        check("t2_ena_pulses", ena_pulses - p0, 1);
        check("t2_ena_width", ena_width, 4);
        check("t2_ena_rise", ena_rise_cyc, c6 + 5);

        // 2b: all six mics simultaneous
        p0 = ena_pulses;
        cyc_wait(2);
        mic_trig = 6'h3F;
        c6 = cyc;
        cyc_wait(20);
        mic_trig = '0;
        wait_idle("t2b");
        check("t2b_delays", 32'(delays()), 32'h00000);
        check("t2b_ena_rise", ena_rise_cyc, c6 + 5);
        check("t2b_ena_width", ena_width, 4);

        // 3: mic4 twenty ticks late saturates
        p0 = ena_pulses;
        cyc_wait(2);
        mic_trig[0] = 1'b1;
        cyc_wait(15);
        mic_trig = 6'b11_0111;
        cyc_wait(190);
        mic_trig[3] = 1'b1;
        cyc_wait(20);
        mic_trig = '0;
        wait_idle("t3");
        check("t3_delays", 32'(delays()), 32'h11F11);
        check("t3_err_order", 32'(err_order), 32'd0);
        check("t3_ena_pulses", ena_pulses - p0, 1);

        // 4: mic3 two ticks ahead of mic1, others three ticks after mic1
        cyc_wait(2);
        mic_trig[2] = 1'b1;
        cyc_wait(25);
        mic_trig[0] = 1'b1;
        cyc_wait(30);
        mic_trig = 6'h3F;
        cyc_wait(20);
        mic_trig = '0;
        wait_idle("t4");
        check("t4_delays", 32'(delays()), 32'h30333);
        check("t4_err_order", 32'(err_order), 32'd1);

        // 5: mic6 never fires
        p0  = ena_pulses;
        t0c = tmo_count;
        cyc_wait(2);
        mic_trig[0] = 1'b1;
        c0 = cyc;
        cyc_wait(15);
        mic_trig = 6'h1F;
        cyc_wait(20);
        mic_trig = '0;
        n = 0;
        while (tmo_count == t0c && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("t5_tmo_seen", 32'(n < 600), 32'd1);
        @(negedge clk);
        d = tmo_cyc - c0;
        check("t5_tmo_time", 32'(d >= 320 && d <= 330), 32'd1);
        cyc_wait(100);
        check("t5_busy_holdoff", 32'(busy), 32'd1);
        wait_idle("t5");
        check("t5_tmo_once", tmo_count - t0c, 1);
        check("t5_no_ena", ena_pulses - p0, 0);
        check("t5_delays_kept", 32'(delays()), 32'h30333);
        check("t5_err_order_kept", 32'(err_order), 32'd1);

        // 6A/6B: edges in HOLDOFF ignored, mic2 held high into IDLE
        p0 = ena_pulses;
        cyc_wait(2);
        mic_trig[0] = 1'b1;
        cyc_wait(15);
        mic_trig = 6'h3F;
        cyc_wait(20);
        mic_trig = '0;
        cyc_wait(20);
        check("t6a_busy", 32'(busy), 32'd1);
        mic_trig = 6'h3F;
        cyc_wait(15);
        mic_trig = 6'h02;
        wait_idle("t6a");
        check("t6a_delays", 32'(delays()), 32'h11111);
        check("t6a_err_order", 32'(err_order), 32'd0);
        check("t6a_ena_pulses", ena_pulses - p0, 1);
        cyc_wait(50);
        check("t6b_idle_busy", 32'(busy), 32'd0);
        check("t6b_no_new_ena", ena_pulses - p0, 1);
        mic_trig = '0;
        cyc_wait(10);

        // 6C: reset mid-capture, then a clean burst
        cyc_wait(2);
        mic_trig[0] = 1'b1;
        cyc_wait(15);
        mic_trig[1] = 1'b1;
        cyc_wait(10);
        check("t6c_busy_before", 32'(busy), 32'd1);
        rst_n    = 1'b0;
        mic_trig = '0;
        cyc_wait(1);
        check("t6c_rst_outs", 32'(all_outs()), 32'd0);
        cyc_wait(3);
        rst_n = 1'b1;
        cyc_wait(8);
        check("t6c_idle_after_rst", 32'(busy), 32'd0);
        p0 = ena_pulses;
        mic_trig[0] = 1'b1;
        cyc_wait(25);
        mic_trig = 6'b11_0111;
        cyc_wait(10);
        mic_trig[3] = 1'b1;
        cyc_wait(20);
        mic_trig = '0;
        wait_idle("t6c");
        check("t6c_delays", 32'(delays()), 32'h22322);
        check("t6c_err_order", 32'(err_order), 32'd0);
        check("t6c_ena_pulses", ena_pulses - p0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
